// File: rtl/press_gen_pkg.sv
// Shared types and constants for the computer-player press generator:
// FSM state encoding plus the 10-bit XNOR LFSR geometry and its step function.
package press_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    PRESS    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam int                LFSR_W      = 10;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 10'h3FF;
  localparam int                TAP_HI      = 9;
  localparam int                TAP_LO      = 6;

  // XNOR feedback keeps all-zeros legal and makes all-ones the stuck state.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ~(v[TAP_HI] ^ v[TAP_LO])};
  endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit XNOR LFSR register: holds its value, steps on step_i, loads on load_i.
// A load of the lockup pattern is replaced by all-zeros so the sequence never sticks.
module lfsr10
  import press_gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              step_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  output logic [LFSR_W-1:0] value_o
);

  logic [LFSR_W-1:0] value_q;
  logic [LFSR_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = (load_val_i == LFSR_LOCKUP) ? '0 : load_val_i;
    end else if (step_i) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/computer_press_gen.sv
// Computer-player key source: prescaled LFSR sample ticks, comparator verdict -> one-cycle
// press, then a cooldown measured in sample ticks. Optional seed port: PRESS_GEN_SEED_EN.
module computer_press_gen
  import press_gen_pkg::*;
#(
  parameter int PRESCALE       = 8,
  parameter int COOLDOWN_TICKS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              round_clr,
  input  logic              cmp_hit,
`ifdef PRESS_GEN_SEED_EN
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
`endif
  output logic [LFSR_W-1:0] rnd,
  output logic              rnd_valid,
  output logic              press,
  output logic              busy,
  output logic [7:0]        press_cnt,
  output state_t            state_dbg
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CD_W = $clog2(COOLDOWN_TICKS + 1);

  // cmp_hit is only meaningful in a cycle where rnd_valid is high; it is the
  // comparator's verdict on the rnd value presented in that same cycle.
  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;
  logic            ps_wrap;
  logic            lfsr_step;
  logic            lfsr_load;
  logic [LFSR_W-1:0] lfsr_load_val;
  logic            rnd_valid_q;
  logic            rnd_valid_d;

  state_t          state_q;
  logic [CD_W-1:0] cd_q;
  logic            press_q;
  logic            busy_q;
  logic [7:0]      press_cnt_q;

  assign ps_wrap = enable && !round_clr && (ps_q == PS_W'(PRESCALE - 1));

  always_comb begin
    ps_d = ps_q;
    if (round_clr) begin
      ps_d = '0;
    end else if (enable) begin
      ps_d = ps_wrap ? '0 : ps_q + PS_W'(1);
    end
  end

`ifdef PRESS_GEN_SEED_EN
  assign lfsr_load     = seed_load;
  assign lfsr_load_val = seed;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
`endif

  // A seed load takes precedence over a step landing in the same cycle.
  assign lfsr_step   = ps_wrap && !lfsr_load;
  assign rnd_valid_d = ps_wrap || lfsr_load;

  lfsr10 u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .step_i    (lfsr_step),
    .load_i    (lfsr_load),
    .load_val_i(lfsr_load_val),
    .value_o   (rnd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q        <= '0;
      rnd_valid_q <= 1'b0;
      state_q     <= IDLE;
      cd_q        <= '0;
      press_q     <= 1'b0;
      busy_q      <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      ps_q        <= ps_d;
      rnd_valid_q <= rnd_valid_d;
      press_q     <= 1'b0;
      if (round_clr) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        press_cnt_q <= '0;
      end else if (!enable) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED: begin
            if (rnd_valid_q && cmp_hit) begin
              state_q <= PRESS;
              press_q <= 1'b1;
              busy_q  <= 1'b1;
              if (press_cnt_q != 8'hFF) begin
                press_cnt_q <= press_cnt_q + 8'd1;
              end
            end
          end
          PRESS: begin
            state_q <= COOLDOWN;
            cd_q    <= CD_W'(COOLDOWN_TICKS);
          end
          COOLDOWN: begin
            // Cooldown length is counted in sample ticks, not clock cycles.
            if (rnd_valid_q) begin
              cd_q <= cd_q - CD_W'(1);
              if (cd_q == CD_W'(1)) begin
                state_q <= ARMED;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rnd_valid = rnd_valid_q;
  assign press     = press_q;
  assign busy      = busy_q;
  assign press_cnt = press_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_computer_press_gen.sv
// Directed bench for computer_press_gen (PRESCALE=4, COOLDOWN_TICKS=2); rnd values are
// tracked through an expected queue checked on every rnd_valid pulse.
module tb_computer_press_gen;
  import press_gen_pkg::*;

  localparam int PRESCALE       = 4;
  localparam int COOLDOWN_TICKS = 2;
  localparam int GAP            = (1 + COOLDOWN_TICKS) * PRESCALE;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       round_clr;
  logic       cmp_hit;
`ifdef PRESS_GEN_SEED_EN
  logic       seed_load;
  logic [9:0] seed;
`endif
  logic [9:0] rnd;
  logic       rnd_valid;
  logic       press;
  logic       busy;
  logic [7:0] press_cnt;
  state_t     state_dbg;

  computer_press_gen #(
    .PRESCALE      (PRESCALE),
    .COOLDOWN_TICKS(COOLDOWN_TICKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .round_clr(round_clr),
    .cmp_hit  (cmp_hit),
`ifdef PRESS_GEN_SEED_EN
    .seed_load(seed_load),
    .seed     (seed),
`endif
    .rnd      (rnd),
    .rnd_valid(rnd_valid),
    .press    (press),
    .busy     (busy),
    .press_cnt(press_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int         n_cmp   = 0;
  int         n_err   = 0;
  int         cyc     = 0;
  int         n_valid = 0;
  bit         press_seen  = 1'b0;
  bit         lockup_seen = 1'b0;
  bit         press_prev  = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] init_tbl [5] = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F};

  function automatic logic [9:0] ref_next(input logic [9:0] v);
    logic fb;
    fb = (v[9] == v[6]);
    return (v << 1) | {9'd0, fb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [9:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (press) press_seen = 1'b1;
    if (press && press_prev) check("press_width", 32'(press_prev), 32'd0);
    press_prev = press;
    if (rnd_valid) begin
      n_valid++;
      if (rnd == 10'h3FF) lockup_seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("rnd_unexpected", 32'(rnd_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rnd_seq", 32'(rnd), 32'(e));
        exp_q.push_back(ref_next(e));
      end
    end
  endtask

  task automatic wait_valid(output int dt);
    int t0;
    bit got;
    t0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      tick();
      got = rnd_valid;
    end
    dt = cyc - t0;
    if (!got) check("valid_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_press(input string tag, output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (press) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    check(tag, 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         dt;
    int         t_prev;
    int         t_now;
    int         nv0;
    logic [9:0] r0;

    reset     = 1'b1;
    enable    = 1'b0;
    round_clr = 1'b0;
    cmp_hit   = 1'b0;
`ifdef PRESS_GEN_SEED_EN
    seed_load = 1'b0;
    seed      = 10'h000;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_rnd",       32'(rnd),       32'h000);
    check("rst_rnd_valid", 32'(rnd_valid), 32'd0);
    check("rst_press",     32'(press),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_press_cnt", 32'(press_cnt), 32'd0);
    check("rst_state",     32'(state_dbg), 32'(IDLE));
    exp_q.push_back(10'h001);

    // Sample ticks every PRESCALE clocks, known opening sequence.
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(dt);
      check("valid_gap", 32'(dt), 32'(PRESCALE));
      check("rnd_init", 32'(rnd), 32'(init_tbl[i]));
    end
    check("armed_after_enable", 32'(state_dbg), 32'(ARMED));

    // Full period back to zero, never through the lockup state.
    for (int i = 0; i < 1018; i++) wait_valid(dt);
    check("rnd_period_wrap", 32'(rnd), 32'h000);
    check("lockup_never",    32'(lockup_seen), 32'd0);
    check("no_press_nohit",  32'(press_seen),  32'd0);

    // Held hit: single-cycle presses spaced by press + cooldown ticks.
    cmp_hit = 1'b1;
    tick();
    check("press1_on",   32'(press),     32'd1);
    check("press1_busy", 32'(busy),      32'd1);
    check("press1_st",   32'(state_dbg), 32'(PRESS));
    t_prev = cyc;
    tick();
    check("press1_off",  32'(press),     32'd0);
    check("press1_cnt",  32'(press_cnt), 32'd1);
    check("cool_state",  32'(state_dbg), 32'(COOLDOWN));
    check("cool_busy",   32'(busy),      32'd1);
    for (int k = 2; k <= 3; k++) begin
      wait_press("press_found", t_now);
      check("press_gap", 32'(t_now - t_prev), 32'(GAP));
      t_prev = t_now;
      tick();
      check("press_off", 32'(press),     32'd0);
      check("press_cnt", 32'(press_cnt), 32'(k));
    end

    // Drop enable mid-cooldown: idle at once, LFSR frozen, then resume.
    tick();
    enable = 1'b0;
    tick();
    check("dis_state", 32'(state_dbg), 32'(IDLE));
    check("dis_busy",  32'(busy),      32'd0);
    check("dis_press", 32'(press),     32'd0);
    r0  = rnd;
    nv0 = n_valid;
    repeat (10) tick();
    check("dis_rnd_frozen", 32'(rnd),     32'(r0));
    check("dis_no_valid",   32'(n_valid), 32'(nv0));
    cmp_hit = 1'b0;
    enable  = 1'b1;
    tick();
    check("reen_state", 32'(state_dbg), 32'(ARMED));
    wait_valid(dt);
    cmp_hit = 1'b1;
    tick();
    check("reen_press", 32'(press), 32'd1);
    cmp_hit = 1'b0;
    tick();
    check("reen_press_off", 32'(press),     32'd0);
    check("reen_cnt",       32'(press_cnt), 32'd4);

    // round_clr coincident with a hit on a fresh sample.
    repeat (3) wait_valid(dt);
    check("clr_pre_state", 32'(state_dbg), 32'(ARMED));
    round_clr = 1'b1;
    cmp_hit   = 1'b1;
    tick();
    check("clr_press", 32'(press),     32'd0);
    check("clr_cnt",   32'(press_cnt), 32'd0);
    check("clr_state", 32'(state_dbg), 32'(IDLE));
    check("clr_busy",  32'(busy),      32'd0);
    round_clr = 1'b0;

    // Asynchronous reset while press is high.
    wait_press("press_rst_found", t_now);
    #2;
    reset = 1'b1;
    #1;
    check("arst_press",     32'(press),     32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_rnd",       32'(rnd),       32'h000);
    check("arst_rnd_valid", 32'(rnd_valid), 32'd0);
    check("arst_cnt",       32'(press_cnt), 32'd0);
    check("arst_state",     32'(state_dbg), 32'(IDLE));
    @(posedge clk);
    #1;
    reset   = 1'b0;
    cmp_hit = 1'b0;
    press_prev = 1'b0;
    exp_q.delete();
    exp_q.push_back(10'h001);
    wait_valid(dt);
    check("post_rst_gap", 32'(dt),  32'(PRESCALE));
    check("post_rst_rnd", 32'(rnd), 32'h001);

`ifdef PRESS_GEN_SEED_EN
    enable = 1'b0;
    tick();
    seed      = 10'h3FF;
    seed_load = 1'b1;
    exp_q.delete();
    exp_q.push_back(10'h000);
    tick();
    seed_load = 1'b0;
    check("seed_lock_rnd",   32'(rnd),       32'h000);
    check("seed_lock_valid", 32'(rnd_valid), 32'd1);
    seed      = 10'h155;
    seed_load = 1'b1;
    exp_q.delete();
    exp_q.push_back(10'h155);
    tick();
    seed_load = 1'b0;
    check("seed_rnd",   32'(rnd),       32'h155);
    check("seed_valid", 32'(rnd_valid), 32'd1);
    enable = 1'b1;
    wait_valid(dt);
    check("seed_step", 32'(rnd), 32'(ref_next(10'h155)));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
